// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle fetch/memory path: PCSrc select, access FSM states, reset PC.
// Also holds the captured memory command layout and the jump-target helper.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_ALURESULT = 2'b00,
    PCSRC_ALUOUT    = 2'b01,
    PCSRC_JUMP      = 2'b10,
    PCSRC_HOLD      = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'b00,
    ACC_REQ  = 2'b01,
    ACC_DONE = 2'b10
  } acc_state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } acc_op_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
    return {pc[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Memory access sequencer IDLE -> REQ -> DONE (min 3 cycles); holds Stall until mem_ready or timeout.
// Command is captured once on leaving IDLE and held stable for the whole request.
module mem_access_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        ir_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        iord,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] write_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        commit_ir,
  output logic        commit_mdr,
  output logic [31:0] rd_data,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  acc_state_t    state, state_nxt;
  acc_op_t       op_q, op_dmd;
  mem_cmd_t      cmd_q;
  logic [CW-1:0] to_cnt;
  logic          demand;
  logic          timeout;

  assign demand  = ir_write | mem_write | mem_read;
  // Fires on the TIMEOUT_CYCLES-th REQ cycle that still has no mem_ready.
  assign timeout = (state == ACC_REQ) && !mem_ready && (to_cnt == TO_LAST);

  always_comb begin
    op_dmd = OP_READ;
    if (ir_write)       op_dmd = OP_FETCH;
    else if (mem_write) op_dmd = OP_WRITE;
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) state <= ACC_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC_IDLE: if (demand) state_nxt = ACC_REQ;
      ACC_REQ:  if (mem_ready || timeout) state_nxt = ACC_DONE;
      ACC_DONE: state_nxt = ACC_IDLE;
      default:  state_nxt = ACC_IDLE;
    endcase
  end

  // Commit only if the strobe that started the access is still asserted.
  always_comb begin
    stall      = demand && (state != ACC_DONE);
    commit_ir  = 1'b0;
    commit_mdr = 1'b0;
    if (state == ACC_DONE) begin
      commit_ir  = (op_q == OP_FETCH) && ir_write;
      commit_mdr = (op_q == OP_READ) && mem_read;
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      cmd_q   <= '0;
      op_q    <= OP_FETCH;
      mem_req <= 1'b0;
      to_cnt  <= '0;
      rd_data <= '0;
      bus_err <= 1'b0;
    end else begin
      mem_req <= (state_nxt == ACC_REQ);
      if (state == ACC_IDLE && demand) begin
        op_q        <= op_dmd;
        cmd_q.addr  <= (op_dmd == OP_FETCH || !iord) ? pc : alu_out;
        cmd_q.wdata <= write_data;
        cmd_q.we    <= (op_dmd == OP_WRITE);
        to_cnt      <= '0;
      end
      if (state == ACC_REQ) begin
        if (mem_ready) begin
          rd_data <= mem_rdata;
        end else begin
          to_cnt <= to_cnt + CW'(1);
          if (timeout) begin
            rd_data <= '0;
            bus_err <= 1'b1;
          end
        end
      end
    end
  end

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

endmodule

// File: rtl/mem_fetch_unit.sv
// Multicycle fetch/memory unit: PC, IR and MDR registers around mem_access_fsm.
// Stall is combinational; PC advances only when not stalled (DONE cycle for fetches).
module mem_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  input  logic        Zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [31:0] Data,
  output logic        Stall,
  output logic        bus_err
);

  logic        commit_ir;
  logic        commit_mdr;
  logic [31:0] rd_data;
  logic [31:0] pc_nxt;
  logic        pc_en;

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access (
    .cclk       (cclk),
    .rstb       (rstb),
    .ir_write   (IRWrite),
    .mem_read   (MemRead),
    .mem_write  (MemWrite),
    .iord       (IorD),
    .pc         (PC),
    .alu_out    (ALUOut),
    .write_data (WriteData),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (Stall),
    .commit_ir  (commit_ir),
    .commit_mdr (commit_mdr),
    .rd_data    (rd_data),
    .bus_err    (bus_err)
  );

  always_comb begin
    pc_nxt = PC;
    case (pcsrc_t'(PCSrc))
      PCSRC_ALURESULT: pc_nxt = ALUResult;
      PCSRC_ALUOUT:    pc_nxt = ALUOut;
      PCSRC_JUMP:      pc_nxt = jump_target(PC, Instr);
      default:         pc_nxt = PC;
    endcase
  end

  assign pc_en = (PCWrite | (Branch & Zero)) & ~Stall;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      PC    <= RESET_PC;
      Instr <= '0;
      Data  <= '0;
    end else begin
      if (pc_en)      PC    <= pc_nxt;
      if (commit_ir)  Instr <= rd_data;
      if (commit_mdr) Data  <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Randomized bench for mem_fetch_unit with a transaction-level reference model.
module tb_mem_fetch_unit;

  localparam int TMO = 255;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        IorD, IRWrite, MemRead, MemWrite, PCWrite, Branch, Zero;
  logic [1:0]  PCSrc;
  logic [31:0] ALUResult, ALUOut, WriteData, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, Stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, PC, Instr, Data;

  mem_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TMO)) dut (
    .cclk(cclk), .rstb(rstb), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
    .ALUResult(ALUResult), .ALUOut(ALUOut), .WriteData(WriteData), .Zero(Zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .PC(PC), .Instr(Instr), .Data(Data),
    .Stall(Stall), .bus_err(bus_err)
  );

  always #5 cclk = ~cclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  logic [31:0] m_pc, m_instr, m_data, m_addr, m_wdata;
  logic        m_we, m_err;
  logic        e_stall, e_req, e_err;
  bit          chk_en = 1'b0;

  int          obs_stall;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge cclk) begin
    if (chk_en) begin
      chk1("Stall", Stall, e_stall);
      chk1("mem_req", mem_req, e_req);
      chk1("bus_err", bus_err, e_err);
      chk1("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("PC", PC, m_pc);
      chk("Instr", Instr, m_instr);
      chk("Data", Data, m_data);
    end
  end

  function automatic logic [31:0] model_next_pc(input logic [1:0] src, input logic [31:0] ar,
                                                input logic [31:0] ao, input logic [31:0] pc,
                                                input logic [31:0] ins);
    case (src)
      2'd0:    return ar;
      2'd1:    return ao;
      2'd2:    return {pc[31:28], ins[25:0], 2'b00};
      default: return pc;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_data = 32'h0;
    m_addr = 32'h0; m_wdata = 32'h0; m_we = 1'b0; m_err = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0;
  endtask

  task automatic idle_inputs();
    IorD = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    PCWrite = 1'b0; Branch = 1'b0; Zero = 1'b0; PCSrc = 2'b11;
    ALUResult = 32'h0; ALUOut = 32'h0; WriteData = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
  endtask

  // One cycle with no memory demand; caller is aligned just after a posedge.
  task automatic do_nomem(input logic pcw, input logic br, input logic z, input logic [1:0] src,
                          input logic [31:0] ar, input logic [31:0] ao);
    IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'($urandom);
    PCWrite = pcw; Branch = br; Zero = z; PCSrc = src; ALUResult = ar; ALUOut = ao;
    WriteData = $urandom; mem_rdata = $urandom; mem_ready = 1'($urandom);
    e_stall = 1'b0; e_req = 1'b0; e_err = m_err;
    @(posedge cclk); #1;
    if (pcw | (br & z)) m_pc = model_next_pc(src, ar, ao, m_pc, m_instr);
  endtask

  // One memory access with strobes held until Stall falls; ready after d wait cycles
  // or never when to=1. Operands wiggle during REQ to prove the command is held.
  task automatic do_mem(input logic ir, input logic mw, input logic mr, input logic iord,
                        input logic pcw, input logic br, input logic z, input logic [1:0] src,
                        input logic [31:0] ar, input logic [31:0] ao, input logic [31:0] wd,
                        input logic [31:0] rd, input int d, input bit to);
    int          rq;
    logic [31:0] a, rdv, old_instr;
    rq = to ? TMO : d + 1;
    a  = (ir || !iord) ? m_pc : ao;
    obs_stall = 0;
    for (int k = 0; k <= rq + 1; k++) begin
      IRWrite = ir; MemWrite = mw; MemRead = mr; IorD = iord;
      PCWrite = pcw; Branch = br; Zero = z; PCSrc = src; ALUResult = ar;
      ALUOut    = (k >= 1 && k <= rq) ? $urandom : ao;
      WriteData = (k >= 1 && k <= rq) ? $urandom : wd;
      mem_ready = (k >= 1 && k <= rq) ? (!to && k == rq) : 1'($urandom);
      mem_rdata = (k == rq && !to) ? rd : $urandom;
      if (k == 1) begin
        m_addr = a; m_wdata = wd; m_we = !ir && mw;
      end
      e_stall = (k <= rq);
      e_req   = (k >= 1 && k <= rq);
      e_err   = m_err | (to && k == rq + 1);
      @(negedge cclk);
      if (Stall) obs_stall++;
      if (k == 1) begin
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
      end
      @(posedge cclk); #1;
    end
    if (to) m_err = 1'b1;
    rdv = to ? 32'h0 : rd;
    old_instr = m_instr;
    if (ir) m_instr = rdv;
    else if (!mw && mr) m_data = rdv;
    if (pcw | (br & z)) m_pc = model_next_pc(src, ar, ao, m_pc, old_instr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    #12;
    chk("rst_PC", PC, 32'h0);
    chk("rst_Instr", Instr, 32'h0);
    chk("rst_Data", Data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_Stall", Stall, 1'b0);
    @(posedge cclk); #1;
    rstb = 1'b1;
    chk_en = 1'b1;

    // Minimal fetch: ready immediately
    do_mem(1, 0, 0, 0, 1, 0, 0, 2'b00, 32'd4, 32'h0, 32'h0, 32'h2002_0005, 0, 0);
    chk("f34_addr", obs_addr, 32'h0);
    chk("f34_stall_cycles", obs_stall, 32'd2);
    chk("f34_Instr", Instr, 32'h2002_0005);
    chk("f34_PC", PC, 32'd4);

    // Fetch with 5 wait cycles
    do_mem(1, 0, 0, 0, 1, 0, 0, 2'b00, 32'd8, 32'h0, 32'h0, 32'h1234_5678, 5, 0);
    chk("f35_stall_cycles", obs_stall, 32'd7);
    chk("f35_addr", obs_addr, 32'd4);
    chk("f35_PC", PC, 32'd8);

    // Store
    do_mem(0, 1, 0, 1, 0, 0, 0, 2'b11, 32'h0, 32'h40, 32'hCAFE, 32'hFFFF_FFFF, 2, 0);
    chk1("w36_we", obs_we, 1'b1);
    chk("w36_addr", obs_addr, 32'h40);
    chk("w36_wdata", obs_wdata, 32'hCAFE);
    chk("w36_Data", Data, 32'h0);

    // Branch taken / not taken
    do_nomem(0, 1, 1, 2'b01, 32'h0, 32'h100);
    chk("b37_taken_PC", PC, 32'h100);
    do_nomem(0, 1, 0, 2'b01, 32'h0, 32'h200);
    chk("b37_nottaken_PC", PC, 32'h100);

    // Jump: PC = A000_0000, Instr[25:0] = 0x10
    do_nomem(1, 0, 0, 2'b00, 32'hA000_0000, 32'h0);
    do_mem(1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0800_0010, 1, 0);
    chk("j38_Instr", Instr, 32'h0800_0010);
    do_nomem(1, 0, 0, 2'b10, 32'h0, 32'h0);
    chk("j38_PC", PC, 32'hA000_0040);
    do_nomem(1, 0, 0, 2'b11, 32'h5555_5555, 32'h6666_6666);
    chk("hold_PC", PC, 32'hA000_0040);

    // Randomized mix, including illegal strobe combinations
    for (int i = 0; i < 150; i++) begin
      int   r;
      logic ir, mw, mr;
      r  = $urandom_range(0, 9);
      ir = (r >= 3 && r <= 5) || (r == 9 && 1'($urandom));
      mw = (r == 8) || (r == 9);
      mr = (r == 6) || (r == 7) || (r == 9);
      if (r < 3)
        do_nomem(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
      else
        do_mem(ir, mw, mr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 6), 0);
    end

    // Demand withdrawn mid-access: finish the bus cycle, discard the commit
    chk_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      IRWrite = (k < 2); MemRead = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; Branch = 1'b0;
      WriteData = 32'h1234; mem_rdata = 32'hDEAD_BEEF; mem_ready = (k == 3);
      @(negedge cclk);
      chk1($sformatf("drop_req%0d", k), mem_req, (k >= 1 && k <= 3));
      chk1($sformatf("drop_stall%0d", k), Stall, (k < 2));
      @(posedge cclk); #1;
    end
    chk("drop_Instr", Instr, m_instr);
    chk("drop_PC", PC, m_pc);
    m_addr = m_pc; m_wdata = 32'h1234; m_we = 1'b0;
    chk_en = 1'b1;

    // Timeout: mem_ready never arrives
    do_mem(1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
    chk1("t39_bus_err", bus_err, 1'b1);
    chk("t39_stall_cycles", obs_stall, TMO + 1);
    chk("t39_Instr", Instr, 32'h0);
    do_mem(0, 0, 1, 1, 0, 0, 0, 2'b11, 32'h0, 32'h80, 32'h0, 32'h0BAD_F00D, 3, 0);
    chk("t39_after_Data", Data, 32'h0BAD_F00D);

    // Asynchronous reset in the middle of REQ
    chk_en = 1'b0;
    IRWrite = 1'b1; mem_ready = 1'b0; PCWrite = 1'b1; PCSrc = 2'b00; ALUResult = 32'h44;
    @(posedge cclk); #1;
    chk1("ar_req_before", mem_req, 1'b1);
    #2 rstb = 1'b0;
    #1;
    chk1("ar_req", mem_req, 1'b0);
    chk1("ar_bus_err", bus_err, 1'b0);
    chk("ar_PC", PC, 32'h0);
    chk("ar_Instr", Instr, 32'h0);
    idle_inputs();
    @(posedge cclk); #1;
    rstb = 1'b1;
    model_reset();
    chk_en = 1'b1;
    do_mem(1, 0, 0, 0, 1, 0, 0, 2'b00, 32'd4, 32'h0, 32'h0, 32'h0C0F_FEE0, 2, 0);
    chk("ar_post_Instr", Instr, 32'h0C0F_FEE0);
    do_nomem(0, 0, 0, 2'b11, 32'h0, 32'h0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fetch_unit.md
MEM_FETCH_UNIT -- requirements
Module: mem_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum cycles an access may wait for mem_ready.
REQ-003 cclk  in  1  single clock; all state changes on posedge.
REQ-004 rstb  in  1  reset, asynchronous assert, active-low.
REQ-005 IorD, IRWrite, MemRead, MemWrite, PCWrite, Branch  in  1 each  control strobes from control_unit.
REQ-006 PCSrc  in  2  next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target, 11 hold.
REQ-007 ALUResult, ALUOut, WriteData  in  32 each  datapath operands; WriteData is store data.
REQ-008 Zero  in  1  ALU zero flag.
REQ-009 mem_req, mem_we  out  1 each  registered memory request and write-enable.
REQ-010 mem_addr, mem_wdata  out  32 each  registered memory address and store data.
REQ-011 mem_rdata  in  32; mem_ready  in  1  read data and completion.
REQ-012 PC, Instr, Data  out  32 each  program counter, instruction register, memory data register.
REQ-013 Stall  out  1  combinational; control_unit holds all strobes while high.
REQ-014 bus_err  out  1  sticky access-timeout flag.

Function
REQ-015 Demand = IRWrite | MemRead | MemWrite; priority IRWrite > MemWrite > MemRead if several assert (illegal, must not hang).
REQ-016 Access FSM states: IDLE, REQ, DONE.
REQ-017 IDLE with demand: capture mem_addr = (IorD ? ALUOut : PC), forced to PC for IRWrite; capture mem_wdata = WriteData and mem_we = MemWrite (0 if IRWrite); go REQ.
REQ-018 REQ: mem_req = 1; mem_addr, mem_wdata and mem_we stable; on mem_ready, capture mem_rdata internally and go DONE.
REQ-019 DONE: mem_req = 0; commit; go IDLE next cycle.
REQ-020 Stall = demand & (state != DONE).
REQ-021 Minimum access latency 3 cycles (demand cycle, REQ with mem_ready = 1, DONE commit).
REQ-022 Commit in DONE: IRWrite loads captured data into Instr; MemRead loads it into Data; MemWrite loads nothing.
REQ-023 PC enable = PCWrite | (Branch & Zero), applied only when Stall = 0.
REQ-024 PC therefore updates in the DONE cycle for fetches, with the address already captured from the old PC, and immediately for non-memory branch/jump cycles.
REQ-025 Jump target = {PC[31:28], Instr[25:0], 2'b00}; PCSrc = 11 leaves PC unchanged even when enabled.
REQ-026 Timeout: a counter increments each REQ cycle without mem_ready; on reaching TIMEOUT_CYCLES, set bus_err and go DONE with captured data 32'h0.
REQ-027 The counter clears on entry to REQ.
REQ-028 Demand deasserting mid-access (control violation): FSM finishes the access, discards the commit, returns to IDLE.
REQ-029 mem_ready outside REQ is ignored.

Reset
REQ-030 On rstb low, asynchronously: state IDLE, PC = RESET_PC, Instr = 0, Data = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, timeout counter 0, bus_err = 0.
REQ-031 Reset mid-access abandons the transaction: mem_req drops immediately and no commit occurs.

Structure
REQ-032 Shared package mips_pkg holds the PCSrc encodings, the access FSM state encoding, and the RESET_PC default.
REQ-033 Access FSM plus timeout counter sits in one sub-module, mem_access_fsm; PC/IR/MDR registers and the next-PC mux stay in the top.

Verification
REQ-034 Reset, then IRWrite = PCWrite = 1, PCSrc = 00, ALUResult = 4, mem_ready tied 1, mem_rdata = 32'h2002_0005 -> mem_addr = 0 in REQ; Stall high 2 cycles; Instr = 32'h2002_0005 and PC = 4 after DONE.
REQ-035 Fetch with mem_ready delayed 5 cycles -> Stall high 7 cycles, mem_addr/mem_req stable throughout, PC unchanged until DONE.
REQ-036 MemWrite, IorD = 1, ALUOut = 32'h40, WriteData = 32'hCAFE -> mem_we = 1, mem_addr = 32'h40, mem_wdata = 32'hCAFE; Data unchanged.
REQ-037 Branch = 1, Zero = 1, PCSrc = 01, ALUOut = 32'h100, no demand -> PC = 32'h100 next edge, Stall = 0; same with Zero = 0 -> PC unchanged.
REQ-038 PC = 32'hA000_0000, Instr[25:0] = 26'h10, PCWrite = 1, PCSrc = 10 -> PC = 32'hA000_0040.
REQ-039 mem_ready never asserted -> bus_err = 1 after 255 REQ cycles, FSM back in IDLE, and rstb pulsed mid-REQ clears mem_req asynchronously.
